// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - elastic MEM/WB pipeline register with one-entry skid buffer
// Optional perf counters: define MEMWB_PERF_EN.
module mem_wb_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wb,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mem_to_reg,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_read_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_wb_data
`ifdef MEMWB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

    logic              m_valid, s_valid;
    logic [1:0]        m_wb, s_wb;
    logic [DATA_W-1:0] m_rdata, s_rdata;
    logic [DATA_W-1:0] m_alu, s_alu;
    logic [REG_AW-1:0] m_rd, s_rd;

    logic accept, pop;

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally
    assign in_ready = ~s_valid;
    assign accept   = in_valid & in_ready;
    assign pop      = m_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_wb    <= '0;
            m_rdata <= '0;
            m_alu   <= '0;
            m_rd    <= '0;
            s_wb    <= '0;
            s_rdata <= '0;
            s_alu   <= '0;
            s_rd    <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (pop && s_valid) begin
            m_wb    <= s_wb;
            m_rdata <= s_rdata;
            m_alu   <= s_alu;
            m_rd    <= s_rd;
            s_valid <= 1'b0;
        end else if (accept && (!m_valid || pop)) begin
            m_wb    <= in_wb;
            m_rdata <= in_read_data;
            m_alu   <= in_alu_result;
            m_rd    <= in_rd;
            m_valid <= 1'b1;
        end else if (accept) begin
            s_wb    <= in_wb;
            s_rdata <= in_read_data;
            s_alu   <= in_alu_result;
            s_rd    <= in_rd;
            s_valid <= 1'b1;
        end else if (pop) begin
            m_valid <= 1'b0;
        end
    end

    assign out_valid      = m_valid;
    assign out_mem_to_reg = m_wb[0];
    assign out_reg_write  = m_wb[1] & m_valid & (m_rd != '0);
    assign out_read_data  = m_rdata;
    assign out_alu_result = m_alu;
    assign out_rd         = m_rd;
    assign out_wb_data    = m_wb[0] ? m_rdata : m_alu;

`ifdef MEMWB_PERF_EN
    // Saturating counters; deliberately untouched by flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (!m_valid && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised, elastic MEM/WB pipeline register for the 64-bit RISC-V core. It carries the writeback controls (Mem_to_Reg, Reg_Write), load data, ALU result/memory address and destination register. It adds a valid/ready handshake with a one-entry skid buffer, a synchronous flush and a registered-side writeback data mux. It sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 64, width of read data, ALU result and writeback data
REG_AW, 5, destination register index width
CNT_W, 32, width of performance counters (used only with MEMWB_PERF_EN)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; drops all held and incoming entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept; equals !skid_valid
in_wb  in  2  bit0 = Mem_to_Reg, bit1 = Reg_Write
in_read_data  in  DATA_W  data-memory read data
in_alu_result  in  DATA_W  ALU result / memory address
in_rd  in  REG_AW  destination register
out_valid  out  1  output entry valid
out_ready  in  1  writeback consumes the entry this cycle
out_mem_to_reg  out  1  registered Mem_to_Reg
out_reg_write  out  1  stored Reg_Write & out_valid & (out_rd != 0)
out_read_data  out  DATA_W  registered read data
out_alu_result  out  DATA_W  registered ALU result
out_rd  out  REG_AW  registered destination
out_wb_data  out  DATA_W  out_mem_to_reg ? out_read_data : out_alu_result (combinational from registers)

Behaviour:
- Storage: main register (M) drives the outputs; skid register (S) is the overflow slot. Each has a valid bit.
- Reset (async, reset_n low): M.valid = S.valid = 0. All payload fields = 0. All outputs read 0, in_ready = 1.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: one cycle in to out when not back-pressured. Throughput is one entry per cycle.
- Per rising edge, no flush:
  - Pop & S.valid: M <= S, S.valid <= 0. An accept cannot occur in this case (in_ready = 0).
  - Accept & (!M.valid | Pop): M <= input, M.valid <= 1.
  - Accept & M.valid & !Pop: S <= input, S.valid <= 1. in_ready drops next cycle.
  - Pop & !Accept & !S.valid: M.valid <= 0.
  - Otherwise: hold. Payload is frozen while out_valid & !out_ready.
- Full condition: M.valid & S.valid. in_ready = 0 until a pop.
- Empty condition: out_valid = 0. out_reg_write is forced 0. Payload registers keep their last values.
- Flush: on a clock edge with flush = 1, M.valid and S.valid <= 0.
  - Flush overrides a simultaneous accept; the incoming entry is dropped.
  - A simultaneous pop still counts as consumed by the downstream stage.
  - in_ready = 1 the cycle after.
- rd == 0: the entry is still stored and popped, but out_reg_write = 0.
- No combinational path from out_ready to in_ready.
- Payload registers load only on accept or skid transfer, not every cycle.

Optional Feature:
MEMWB_PERF_EN
- Defined: adds outputs perf_stall_cnt [CNT_W] and perf_bubble_cnt [CNT_W].
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_bubble_cnt increments each cycle with !out_valid.
  - Both saturate at all-ones, reset to 0 asynchronously, and are not cleared by flush.
- Undefined: ports and counters are absent. The handshake and datapath behaviour is identical either way.

Test Plan:
- Reset mid-stream: with M and S both valid, pull reset_n low asynchronously -> out_valid = 0, in_ready = 1 and out_* = 0 immediately, without waiting for a clock edge.
- Streaming, out_ready = 1: send rd = 1..4, wb = 2'b10, alu = 0x10,0x20,0x30,0x40 -> each appears one cycle later. out_wb_data = alu value, out_reg_write = 1, in_ready stays 1.
- Back-pressure: out_ready = 0, send A (rd=3) then B (rd=4) -> out holds A, in_ready = 0 after B. Raise out_ready -> A then B pop on consecutive cycles, in order, and in_ready returns to 1.
- Load select: wb = 2'b11, read_data = 0xDEAD_BEEF, alu = 0x1000 -> out_wb_data = 0xDEAD_BEEF. With wb = 2'b10 -> out_wb_data = 0x1000.
- rd = 0 with wb = 2'b10 -> out_valid = 1, out_reg_write = 0.
- Flush while full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the incoming entry never appears. With MEMWB_PERF_EN, 3 stalled cycles give perf_stall_cnt = 3, and the counters are unaffected by the flush.
